// File: rtl/cim_adder_pkg.sv
// Shared types and width helpers for the CIM adder-tree pipeline.
// Sizes the tree levels, the inter-level bus and the accumulator state encoding.
package cim_adder_pkg;

  typedef enum logic {IDLE = 1'b0, ACC = 1'b1} acc_state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int sum_width(input int in_w, input int num_in);
    return in_w + clog2(num_in);
  endfunction

  // Operand count after a number of pairwise levels; an odd operand rides with a zero partner.
  function automatic int count_at(input int num_in, input int level);
    int c;
    c = num_in;
    for (int i = 0; i < level; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Bit offset of a level's results inside the concatenated inter-level bus (levels start at 1).
  function automatic int bus_offset(input int num_in, input int in_w, input int level);
    int o;
    o = 0;
    for (int i = 1; i < level; i++) o += count_at(num_in, i) * (in_w + i);
    return o;
  endfunction

endpackage

// File: rtl/cim_adder_level.sv
// One registered adder level: sums operand pairs into results one bit wider.
// Control bits travel with valid; data registers hold while no valid frame is present.
module cim_adder_level
  import cim_adder_pkg::*;
#(
  parameter int NUM_PAIRS = 1,
  parameter int IN_CNT    = 2,
  parameter int IN_W      = 8,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          vld,
  input  logic                          first,
  input  logic                          mode,
  input  logic [IN_CNT*IN_W-1:0]        data,
  output logic                          sum_vld,
  output logic                          sum_first,
  output logic                          sum_mode,
  output logic [NUM_PAIRS*(IN_W+1)-1:0] sum_data
);

  localparam int SW = IN_W + 1;

  logic [NUM_PAIRS*SW-1:0] sum_c;

  function automatic logic signed [SW-1:0] extend(input logic [IN_W-1:0] v);
    return SIGNED ? {v[IN_W-1], v} : {1'b0, v};
  endfunction

  for (genvar p = 0; p < NUM_PAIRS; p++) begin : g_pair
    logic signed [SW-1:0] a_x;
    logic signed [SW-1:0] b_x;
    assign a_x = extend(data[2*p*IN_W +: IN_W]);
    if (2*p + 1 < IN_CNT) begin : g_pair_b
      assign b_x = extend(data[(2*p+1)*IN_W +: IN_W]);
    end else begin : g_pair_zero
      assign b_x = '0;
    end
    assign sum_c[p*SW +: SW] = a_x + b_x;
  end

  // level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_vld   <= 1'b0;
      sum_first <= 1'b0;
      sum_mode  <= 1'b0;
      sum_data  <= '0;
    end else begin
      sum_vld <= vld;
      if (vld) begin
        sum_first <= first;
        sum_mode  <= mode;
        sum_data  <= sum_c;
      end
    end
  end

endmodule

// File: rtl/cim_adder_tree_pipe.sv
// Pipelined adder tree reducing NUM_IN bank read-outs to one sum per cycle,
// followed by a pass-through / accumulate stage (plain sum or MSB-first shift-add).
module cim_adder_tree_pipe
  import cim_adder_pkg::*;
#(
  parameter int NUM_IN  = 16,
  parameter int IN_W    = 8,
  parameter bit SIGNED  = 1'b0,
  parameter int ACC_LEN = 8,
  parameter bit SHIFT   = 1'b0,
  parameter bit MSB_NEG = 1'b0,
  parameter int OUT_W   = 20,
  localparam int SUM_W  = sum_width(IN_W, NUM_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_first,
  input  logic                   acc_mode,
  output logic [SUM_W-1:0]       tree_sum,
  output logic                   tree_valid,
  output logic [OUT_W-1:0]       acc_out,
  output logic                   acc_valid,
  output logic                   acc_err
);

  localparam int LEVELS = clog2(NUM_IN);
  localparam int BUS_W  = bus_offset(NUM_IN, IN_W, LEVELS + 1);
  localparam int CNT_W  = clog2(ACC_LEN + 1);

  logic                   vld_p0;
  logic                   first_p0;
  logic                   mode_p0;
  logic [NUM_IN*IN_W-1:0] data_p0;

  logic [BUS_W-1:0] lvl_data;
  logic [LEVELS:1]  lvl_vld;
  logic [LEVELS:1]  lvl_first;
  logic [LEVELS:1]  lvl_mode;

  // stage 0: input register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      mode_p0  <= 1'b0;
      data_p0  <= '0;
    end else begin
      vld_p0 <= in_valid;
      if (in_valid) begin
        first_p0 <= in_first;
        mode_p0  <= acc_mode;
        data_p0  <= in_data;
      end
    end
  end

  // stages 1..LEVELS: adder levels chained through one concatenated bus
  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    localparam int N_SRC = count_at(NUM_IN, j - 1);
    localparam int N_DST = count_at(NUM_IN, j);
    localparam int W_SRC = IN_W + j - 1;

    logic                   src_vld;
    logic                   src_first;
    logic                   src_mode;
    logic [N_SRC*W_SRC-1:0] src_data;

    if (j == 1) begin : g_head
      assign src_vld   = vld_p0;
      assign src_first = first_p0;
      assign src_mode  = mode_p0;
      assign src_data  = data_p0;
    end else begin : g_chain
      assign src_vld   = lvl_vld[j-1];
      assign src_first = lvl_first[j-1];
      assign src_mode  = lvl_mode[j-1];
      assign src_data  = lvl_data[bus_offset(NUM_IN, IN_W, j - 1) +: N_SRC*W_SRC];
    end

    cim_adder_level #(
      .NUM_PAIRS(N_DST),
      .IN_CNT   (N_SRC),
      .IN_W     (W_SRC),
      .SIGNED   (SIGNED)
    ) u_level (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld      (src_vld),
      .first    (src_first),
      .mode     (src_mode),
      .data     (src_data),
      .sum_vld  (lvl_vld[j]),
      .sum_first(lvl_first[j]),
      .sum_mode (lvl_mode[j]),
      .sum_data (lvl_data[bus_offset(NUM_IN, IN_W, j) +: N_DST*(W_SRC+1)])
    );
  end

  assign tree_sum   = lvl_data[BUS_W-1 -: SUM_W];
  assign tree_valid = lvl_vld[LEVELS];

  function automatic logic signed [OUT_W-1:0] extend_out(input logic [SUM_W-1:0] s);
    if (SIGNED) return OUT_W'(signed'(s));
    return OUT_W'(s);
  endfunction

  function automatic logic signed [OUT_W-1:0] first_load(input logic signed [OUT_W-1:0] f);
    return (SHIFT && MSB_NEG) ? -f : f;
  endfunction

  function automatic logic signed [OUT_W-1:0] accumulate(input logic signed [OUT_W-1:0] a,
                                                         input logic signed [OUT_W-1:0] f);
    return SHIFT ? (a <<< 1) + f : a + f;
  endfunction

  acc_state_t              state_q;
  acc_state_t              state_n;
  logic signed [OUT_W-1:0] acc_q;
  logic signed [OUT_W-1:0] acc_n;
  logic signed [OUT_W-1:0] frame;
  logic signed [OUT_W-1:0] out_n;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_n;
  logic                    vld_n;
  logic                    err_n;

  // A first-tagged frame in ACC aborts the group and re-evaluates acc_mode.
  always_comb begin
    state_n = state_q;
    acc_n   = acc_q;
    cnt_n   = cnt_q;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    out_n   = acc_out;
    frame   = extend_out(tree_sum);
    if (tree_valid) begin
      if (state_q == ACC && !lvl_first[LEVELS]) begin
        acc_n = accumulate(acc_q, frame);
        cnt_n = cnt_q + 1'b1;
        if (cnt_n == CNT_W'(ACC_LEN - 1)) begin
          vld_n   = 1'b1;
          out_n   = acc_n;
          state_n = IDLE;
        end
      end else begin
        err_n   = (state_q == ACC);
        state_n = IDLE;
        if (!lvl_mode[LEVELS]) begin
          vld_n = 1'b1;
          out_n = frame;
        end else if (lvl_first[LEVELS]) begin
          acc_n = first_load(frame);
          cnt_n = '0;
          if (ACC_LEN == 1) begin
            vld_n = 1'b1;
            out_n = acc_n;
          end else begin
            state_n = ACC;
          end
        end else begin
          err_n = 1'b1;
        end
      end
    end
  end

  // stage LEVELS+1: accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out   <= '0;
      acc_valid <= 1'b0;
      acc_err   <= 1'b0;
    end else begin
      state_q   <= state_n;
      acc_q     <= acc_n;
      cnt_q     <= cnt_n;
      acc_out   <= out_n;
      acc_valid <= vld_n;
      acc_err   <= err_n;
    end
  end

endmodule
